// File: rtl/move_digit_pkg.sv
// Shared encodings, frame defaults and the seven-segment glyph table.
package move_digit_pkg;

  typedef enum logic [1:0] {
    MODE_VERT  = 2'd0,
    MODE_HORIZ = 2'd1,
    MODE_DIAG  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] ORANGE = 16'hFDA0;

  // Segment set {a,b,c,d,e,f,g} for a digit; codes above 9 light nothing.
  function automatic logic [6:0] seg_map(input logic [3:0] v);
    case (v)
      4'd0:    seg_map = 7'b1111110;
      4'd1:    seg_map = 7'b0110000;
      4'd2:    seg_map = 7'b1101101;
      4'd3:    seg_map = 7'b1111001;
      4'd4:    seg_map = 7'b0110011;
      4'd5:    seg_map = 7'b1011011;
      4'd6:    seg_map = 7'b1011111;
      4'd7:    seg_map = 7'b1110000;
      4'd8:    seg_map = 7'b1111111;
      4'd9:    seg_map = 7'b1111011;
      default: seg_map = 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/draw_digit.sv
// Seven-segment glyph rasteriser: colour when (px,py) falls on a lit stroke.
module draw_digit
  import move_digit_pkg::*;
#(
  parameter int DIGIT_WIDTH     = 16,
  parameter int DIGIT_HEIGHT    = 24,
  parameter int DIGIT_THICKNESS = 4
) (
  input  logic [6:0]  px,
  input  logic [6:0]  py,
  input  logic [6:0]  base_x,
  input  logic [6:0]  base_y,
  input  logic [3:0]  value,
  input  logic        set,
  input  logic [15:0] colour,
  output logic [15:0] pixel
);

  localparam logic [7:0] W      = 8'(DIGIT_WIDTH);
  localparam logic [7:0] H      = 8'(DIGIT_HEIGHT);
  localparam logic [7:0] T      = 8'(DIGIT_THICKNESS);
  localparam logic [7:0] HALF   = 8'(DIGIT_HEIGHT / 2);
  localparam logic [7:0] MID_LO = 8'((DIGIT_HEIGHT - DIGIT_THICKNESS) / 2);
  localparam logic [7:0] MID_HI = 8'((DIGIT_HEIGHT + DIGIT_THICKNESS) / 2);

  logic [7:0] rx, ry;
  logic       in_box, top, bot, mid, left, right, upper, lit;
  logic [6:0] seg;

  // Sprite-relative coordinates, stroke regions, then segment selection.
  always_comb begin
    rx     = {1'b0, px} - {1'b0, base_x};
    ry     = {1'b0, py} - {1'b0, base_y};
    in_box = (px >= base_x) && (py >= base_y) && (rx < W) && (ry < H);
    top    = ry < T;
    bot    = ry >= H - T;
    mid    = (ry >= MID_LO) && (ry < MID_HI);
    left   = rx < T;
    right  = rx >= W - T;
    upper  = ry < HALF;
    seg    = seg_map(value);
    lit    = (seg[6] & top)
           | (seg[5] & right & upper)
           | (seg[4] & right & ~upper)
           | (seg[3] & bot)
           | (seg[2] & left & ~upper)
           | (seg[1] & left & upper)
           | (seg[0] & mid);
    pixel  = (set && in_box && lit) ? colour : '0;
  end

endmodule

// File: rtl/tick_gen.sv
// Clock-enable generator: one-cycle tick every DIV enabled cycles.
module tick_gen #(
  parameter int DIV = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Gated by en so a frozen counter parked on the last count cannot repeat ticks.
  assign tick = en && (cnt == CW'(DIV - 1));

  // Free-running divider that simply holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/move_digit_bounce.sv
// Bouncing seven-segment sprite: per-axis bounce motion on a clock-enable tick.
module move_digit_bounce
  import move_digit_pkg::*;
#(
  parameter int          OLED_WIDTH      = OLED_W,
  parameter int          OLED_HEIGHT     = OLED_H,
  parameter int          DIGIT_WIDTH     = 16,
  parameter int          DIGIT_HEIGHT    = 24,
  parameter int          DIGIT_THICKNESS = 4,
  parameter int          TICK_DIV        = 4000000,
  parameter logic [15:0] COLOUR          = ORANGE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [1:0]  speed,
  input  logic [3:0]  value,
  input  logic [6:0]  px,
  input  logic [6:0]  py,
  output logic [15:0] pixel_data,
  output logic [6:0]  base_x,
  output logic [6:0]  base_y,
  output logic        bounce
);

  localparam logic [7:0] X_MAX8 = 8'(OLED_WIDTH - DIGIT_WIDTH);
  localparam logic [7:0] Y_MAX8 = 8'(OLED_HEIGHT - DIGIT_HEIGHT);
  localparam logic [6:0] X_MAX  = 7'(OLED_WIDTH - DIGIT_WIDTH);
  localparam logic [6:0] Y_MAX  = 7'(OLED_HEIGHT - DIGIT_HEIGHT);
  localparam logic [6:0] X_HOME = 7'((OLED_WIDTH - DIGIT_WIDTH) / 2);
  localparam logic [6:0] Y_HOME = 7'd0;

  logic       tick, mode_chg, move_x, move_y, hit_x, hit_y;
  logic       dir_x, dir_y;  // 1 = towards MAX
  logic [1:0] mode_q;
  logic [3:0] value_q;
  logic [6:0] step;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enable),
    .tick  (tick)
  );

  // A pending mode change swallows a coincident tick: reposition only.
  assign mode_chg = (mode != mode_q);
  assign step     = {5'd0, speed} + 7'd1;
  assign move_x   = tick && !mode_chg && (mode == MODE_HORIZ || mode == MODE_DIAG);
  assign move_y   = tick && !mode_chg && (mode == MODE_VERT  || mode == MODE_DIAG);
  // Forward sum done in 8 bits so pos+step cannot wrap past 127.
  assign hit_x    = dir_x ? ({1'b0, base_x} + {1'b0, step} >= X_MAX8) : (base_x <= step);
  assign hit_y    = dir_y ? ({1'b0, base_y} + {1'b0, step} >= Y_MAX8) : (base_y <= step);

  // X axis: home on entering VERT, else step/clamp/reflect on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_x <= X_HOME;
      dir_x  <= 1'b1;
    end else if (mode_chg && mode == MODE_VERT) begin
      base_x <= X_HOME;
      dir_x  <= 1'b1;
    end else if (move_x) begin
      if (dir_x) base_x <= hit_x ? X_MAX : base_x + step;
      else       base_x <= hit_x ? 7'd0  : base_x - step;
      if (hit_x) dir_x <= ~dir_x;
    end
  end

  // Y axis: home on entering HORIZ, else step/clamp/reflect on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_y <= Y_HOME;
      dir_y  <= 1'b1;
    end else if (mode_chg && mode == MODE_HORIZ) begin
      base_y <= Y_HOME;
      dir_y  <= 1'b1;
    end else if (move_y) begin
      if (dir_y) base_y <= hit_y ? Y_MAX : base_y + step;
      else       base_y <= hit_y ? 7'd0  : base_y - step;
      if (hit_y) dir_y <= ~dir_y;
    end
  end

  // One pulse per tick even when both axes clamp together (corner hit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bounce <= 1'b0;
    else        bounce <= (move_x && hit_x) || (move_y && hit_y);
  end

  // Mode tracked every cycle; glyph latched only on tick to avoid tearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 2'd0;
      value_q <= 4'd0;
    end else begin
      mode_q <= mode;
      if (tick) value_q <= value;
    end
  end

  draw_digit #(
    .DIGIT_WIDTH     (DIGIT_WIDTH),
    .DIGIT_HEIGHT    (DIGIT_HEIGHT),
    .DIGIT_THICKNESS (DIGIT_THICKNESS)
  ) u_draw (
    .px     (px),
    .py     (py),
    .base_x (base_x),
    .base_y (base_y),
    .value  (value_q),
    .set    (1'b1),
    .colour (COLOUR),
    .pixel  (pixel_data)
  );

endmodule

// File: tb/tb_move_digit_bounce.sv
// Scoreboard bench for move_digit_bounce with a 4-cycle motion tick.
module tb_move_digit_bounce;

  localparam int TD = 4;

  logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
  logic [1:0]  mode = 2'd0, speed = 2'd0;
  logic [3:0]  value = 4'd0;
  logic [6:0]  px = 7'd0, py = 7'd0;
  logic [15:0] pixel_data;
  logic [6:0]  base_x, base_y;
  logic        bounce;

  always #5 clk = ~clk;

  move_digit_bounce #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .speed      (speed),
    .value      (value),
    .px         (px),
    .py         (py),
    .pixel_data (pixel_data),
    .base_x     (base_x),
    .base_y     (base_y),
    .bounce     (bounce)
  );

  typedef struct {int x; int y; int b;} exp_t;
  exp_t sb[$];

  int errs = 0, checks = 0;
  int cnt = 0;           // expected tick-counter value
  bit ticked = 0;
  int cur_x = 40, cur_y = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    ticked = 0;
    if (rst_n && enable) begin
      if (cnt == TD - 1) begin ticked = 1; cnt = 0; end
      else cnt++;
    end
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_bounce"}, bounce, 0);
    chk({tag, "_x"}, base_x, cur_x);
    chk({tag, "_y"}, base_y, cur_y);
  endtask

  task automatic push(input int x, input int y, input int b);
    exp_t e;
    e.x = x; e.y = y; e.b = b;
    sb.push_back(e);
  endtask

  task automatic run_tick();
    int n = 0;
    exp_t e;
    do begin
      cyc();
      n++;
      if (!ticked) idle_chk("idle");
    end while (!ticked && n < 3 * TD);
    if (!ticked) begin chk("tick_timeout", 0, 1); return; end
    e = sb.pop_front();
    chk("tick_x", base_x, e.x);
    chk("tick_y", base_y, e.y);
    chk("tick_bounce", bounce, e.b);
    cur_x = e.x; cur_y = e.y;
  endtask

  task automatic drain();
    while (sb.size() > 0) run_tick();
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp);
    px = 7'(x); py = 7'(y);
    #1;
    chk(tag, pixel_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 2'd0; speed = 2'd3; value = 4'd7; enable = 1'b0;
    // Async reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x", base_x, 40);
    chk("rst_y", base_y, 0);
    chk("rst_bounce", bounce, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; cnt = 0; cur_x = 40; cur_y = 0;

    // VERT, step 4: up to 40 with bounce, then back down to 8.
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) push(40, 4 * k, (k == 10) ? 1 : 0);
    for (int y = 36; y >= 8; y -= 4) push(40, y, 0);
    drain();

    // Glyph 7 at (40,8).
    pix("pix_top", 41, 9, 16'hFDA0);
    pix("pix_left_out", 39, 9, 0);
    pix("pix_right_c", 55, 20, 16'hFDA0);
    pix("pix_mid_off", 46, 19, 0);
    pix("pix_right_out", 56, 9, 0);

    // Freeze for 10 cycles mid-count; tick must then arrive 10 cycles late.
    value = 4'd12;
    cyc(); idle_chk("pre");
    cyc(); idle_chk("pre");
    enable = 1'b0;
    repeat (10) begin cyc(); idle_chk("frz"); end
    enable = 1'b1;
    push(40, 4, 0);
    drain();
    pix("pix_blank_top", 41, 5, 0);
    pix("pix_blank_c", 55, 16, 0);
    pix("pix_blank_mid", 46, 15, 0);

    // Enter HORIZ: y homes, x keeps 40.
    mode = 2'd1; speed = 2'd1;
    cur_y = 0;
    cyc(); idle_chk("horiz_entry");
    for (int i = 1; i <= 19; i++) push(40 + 2 * i, 0, 0);
    drain();
    speed = 2'd2;
    push(80, 0, 1);
    for (int x = 77; x >= 2; x -= 3) push(x, 0, 0);
    push(0, 0, 1);
    drain();

    // Async reset mid-run while bounce is high and base is off home.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", base_x, 40);
    chk("arst_y", base_y, 0);
    chk("arst_bounce", bounce, 0);
    mode = 2'd0; enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; cnt = 0; cur_x = 40; cur_y = 0;

    // Mode change on the tick cycle: reposition only, no step.
    enable = 1'b1; speed = 2'd2;
    repeat (3) begin cyc(); idle_chk("coin_pre"); end
    mode = 2'd2;
    cyc();
    if (!ticked) chk("coin_tick_missing", 0, 1);
    chk("coin_x", base_x, 40);
    chk("coin_y", base_y, 0);
    chk("coin_bounce", bounce, 0);
    push(43, 3, 0);
    drain();

    // DIAG corner from reset, step 1.
    speed = 2'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; cnt = 0; cur_x = 40; cur_y = 0;
    for (int k = 1; k <= 39; k++) push(40 + k, k, 0);
    push(80, 40, 1);
    push(79, 39, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
